// File: rtl/bht_controller.sv
// Branch history table controller.
// Owns N 2-bit saturating counters, sweeps them to weakly-not-taken after
// reset or flush, serves one-cycle fetch lookups and trains counters from a
// small FIFO of resolved-branch updates so execute never waits on the sweep.
module bht_controller #(
    parameter int INDEX_BITS = 6,
    parameter int UPD_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  lookup_valid,
    input  logic [INDEX_BITS-1:0] lookup_index,
    output logic                  lookup_ready,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic                  pred_strong,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    output logic                  update_ready,
    output logic                  busy
);

    localparam int N  = 1 << INDEX_BITS;
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;

    // Counter array; contents after reset are irrelevant until the sweep runs.
    logic [1:0]            table_q [N];

    // Update FIFO storage and bookkeeping.
    logic [INDEX_BITS-1:0] fifo_idx_q [UPD_DEPTH];
    logic                  fifo_tkn_q [UPD_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    logic                  pred_valid_q, pred_taken_q, pred_strong_q;

    logic                  lookup_acc;
    logic                  enq, deq;
    logic [INDEX_BITS-1:0] head_idx;
    logic                  head_tkn;
    logic [1:0]            head_cnt, head_trained;
    logic [1:0]            lookup_cnt;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_waddr;
    logic [1:0]            tbl_wdata;

    assign busy         = (state_q == ST_INIT);
    assign lookup_ready = (state_q == ST_RUN) && !flush;
    // Full check uses the registered count only: no pass-through when full.
    assign update_ready = (count_q != CW'(UPD_DEPTH));

    assign lookup_acc = lookup_valid && lookup_ready;
    assign enq        = update_valid && update_ready && !flush;
    assign deq        = (state_q == ST_RUN) && (count_q != '0) && !flush;

    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign head_tkn   = fifo_tkn_q[rd_ptr_q];
    assign head_cnt   = table_q[head_idx];
    // Lookup reads the array before this cycle's write, giving pre-write data.
    assign lookup_cnt = table_q[lookup_index];

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_strong = pred_strong_q;

    // Saturating train of the FIFO head counter; never wraps.
    always_comb begin
        head_trained = head_cnt;
        if (head_tkn) begin
            if (head_cnt != 2'b11) head_trained = head_cnt + 2'd1;
        end else begin
            if (head_cnt != 2'b00) head_trained = head_cnt - 2'd1;
        end
    end

    // Next state: flush restarts the sweep; the sweep ends after the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (flush) begin
            state_d = ST_INIT;
            ptr_d   = '0;
        end else if (state_q == ST_INIT) begin
            if (&ptr_q) state_d = ST_RUN;
            else        ptr_d   = ptr_q + 1'b1;
        end
    end

    // Single array write port: sweep write in INIT, head training in RUN.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = ptr_q;
        tbl_wdata = 2'b01;
        if (!flush) begin
            if (state_q == ST_INIT) begin
                tbl_we = 1'b1;
            end else if (deq) begin
                tbl_we    = 1'b1;
                tbl_waddr = head_idx;
                tbl_wdata = head_trained;
            end
        end
    end

    // FIFO occupancy: simultaneous enqueue and dequeue cancel; flush empties it.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Controller state, sweep pointer and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Counter array write.
    always_ff @(posedge clk) begin
        if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    end

    // FIFO payload write.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_idx_q[wr_ptr_q] <= update_index;
            fifo_tkn_q[wr_ptr_q] <= update_taken;
        end
    end

    // Prediction registers: valid pulses per accepted lookup, data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_strong_q <= 1'b0;
        end else begin
            pred_valid_q <= lookup_acc;
            if (lookup_acc) begin
                pred_taken_q  <= lookup_cnt[1];
                pred_strong_q <= (lookup_cnt == 2'b00) || (lookup_cnt == 2'b11);
            end
        end
    end

endmodule

// File: tb/tb_bht_controller.sv
// Self-checking bench for bht_controller: directed vectors plus randomized
// traffic compared every cycle against a queue/array reference model.
module tb_bht_controller;

    localparam int IB = 6;
    localparam int D  = 4;
    localparam int N  = 1 << IB;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          lookup_valid;
    logic [IB-1:0] lookup_index;
    logic          lookup_ready;
    logic          pred_valid;
    logic          pred_taken;
    logic          pred_strong;
    logic          update_valid;
    logic [IB-1:0] update_index;
    logic          update_taken;
    logic          update_ready;
    logic          busy;

    bht_controller #(.INDEX_BITS(IB), .UPD_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .lookup_ready (lookup_ready),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_strong  (pred_strong),
        .update_valid (update_valid),
        .update_index (update_index),
        .update_taken (update_taken),
        .update_ready (update_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: counters as plain integers, pending updates as a queue.
    typedef struct {
        int idx;
        bit tkn;
    } upd_t;

    upd_t m_q[$];
    int   m_tbl[N];
    bit   m_init;
    int   m_ptr;
    bit   m_pv, m_pt, m_ps;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int n;
        bit dir;
        bit exp_t;
        bit exp_s;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_init = 1'b1;
        m_ptr  = 0;
        m_q.delete();
        m_pv = 1'b0;
        m_pt = 1'b0;
        m_ps = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs now driven.
    function automatic void model_step();
        bit   lr, ur, acc;
        int   old;
        upd_t e;
        lr = !m_init && !flush;
        ur = (m_q.size() < D);
        if (flush) begin
            m_init = 1'b1;
            m_ptr  = 0;
            m_q.delete();
            m_pv = 1'b0;
            return;
        end
        acc = lookup_valid && lr;
        old = m_tbl[lookup_index];
        if (!m_init && m_q.size() > 0) begin
            e = m_q.pop_front();
            if (e.tkn) m_tbl[e.idx] = (m_tbl[e.idx] == 3) ? 3 : m_tbl[e.idx] + 1;
            else       m_tbl[e.idx] = (m_tbl[e.idx] == 0) ? 0 : m_tbl[e.idx] - 1;
        end
        if (update_valid && ur) begin
            e.idx = int'(update_index);
            e.tkn = update_taken;
            m_q.push_back(e);
        end
        if (m_init) begin
            m_tbl[m_ptr] = 1;
            if (m_ptr == N - 1) m_init = 1'b0;
            else                m_ptr++;
        end
        m_pv = acc;
        if (acc) begin
            m_pt = (old >= 2);
            m_ps = (old == 0) || (old == 3);
        end
    endfunction

    task automatic compare_all();
        chk("busy",         busy,         m_init);
        chk("lookup_ready", lookup_ready, !m_init && !flush);
        chk("update_ready", update_ready, m_q.size() < D);
        chk("pred_valid",   pred_valid,   m_pv);
        chk("pred_taken",   pred_taken,   m_pt);
        chk("pred_strong",  pred_strong,  m_ps);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_update(input int idx, input bit t);
        update_valid = 1'b1;
        update_index = IB'(idx);
        update_taken = t;
        cycle();
        update_valid = 1'b0;
    endtask

    task automatic do_lookup(input string name, input int idx, input bit et, input bit es);
        lookup_valid = 1'b1;
        lookup_index = IB'(idx);
        cycle();
        lookup_valid = 1'b0;
        chk({name, "_pv"}, pred_valid, 1'b1);
        chk({name, "_taken"}, pred_taken, et);
        chk({name, "_strong"}, pred_strong, es);
        $display("lookup %-12s idx=%0d taken=%b strong=%b", name, idx, pred_taken, pred_strong);
    endtask

    // Counts edges until busy drops, bounded so a stuck sweep cannot hang the run.
    task automatic sweep_len(input string name, input int exp_len);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            n++;
            if (!busy) break;
        end
        chk_int(name, n, exp_len);
        $display("sweep %-12s busy_cycles=%0d", name, n);
    endtask

    initial begin
        int acc_cnt;
        rst          = 1'b1;
        flush        = 1'b0;
        lookup_valid = 1'b0;
        lookup_index = '0;
        update_valid = 1'b0;
        update_index = '0;
        update_taken = 1'b0;
        for (int i = 0; i < N; i++) m_tbl[i] = 0;
        model_reset();

        vecs[0] = '{5, 3, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{5, 2, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{5, 4, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{12, 1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{12, 1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{40, 1, 1'b0, 1'b0, 1'b1};

        // Reset values while rst is held.
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",         busy,         1'b1);
        chk("rst_lookup_ready", lookup_ready, 1'b0);
        chk("rst_update_ready", update_ready, 1'b1);
        chk("rst_pred_valid",   pred_valid,   1'b0);
        chk("rst_pred_taken",   pred_taken,   1'b0);
        chk("rst_pred_strong",  pred_strong,  1'b0);

        // Updates held valid from reset: only D are buffered during the sweep.
        update_valid = 1'b1;
        update_index = IB'(9);
        update_taken = 1'b1;
        rst          = 1'b0;
        acc_cnt      = 0;
        begin
            int n;
            n = 0;
            for (int i = 0; i < 200; i++) begin
                if (update_valid && update_ready) acc_cnt++;
                cycle();
                n++;
                if (!busy) break;
            end
            chk_int("init_sweep_len", n, N);
        end
        chk_int("init_accepted", acc_cnt, D);
        chk("init_full_ready", update_ready, 1'b0);
        update_valid = 1'b0;
        cycle();
        chk("ready_after_first_deq", update_ready, 1'b1);
        repeat (3) cycle();
        do_lookup("buffered_idx9", 9, 1'b1, 1'b1);

        // Saturation vectors.
        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].n; k++) do_update(vecs[v].idx, vecs[v].dir);
            cycle();
            do_lookup($sformatf("vec%0d", v), vecs[v].idx, vecs[v].exp_t, vecs[v].exp_s);
        end

        // Same-index collision: lookup one cycle after the update sees the old value.
        do_update(20, 1'b1);
        do_lookup("collide_t1", 20, 1'b0, 1'b0);
        do_lookup("collide_t2", 20, 1'b1, 1'b0);

        // Async reset mid-drain with a strong-taken prediction registered.
        lookup_valid = 1'b1;
        lookup_index = IB'(9);
        update_valid = 1'b1;
        update_index = IB'(9);
        update_taken = 1'b1;
        cycle();
        model_step();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",         busy,         1'b1);
        chk("arst_lookup_ready", lookup_ready, 1'b0);
        chk("arst_update_ready", update_ready, 1'b1);
        chk("arst_pred_valid",   pred_valid,   1'b0);
        chk("arst_pred_taken",   pred_taken,   1'b0);
        chk("arst_pred_strong",  pred_strong,  1'b0);
        model_reset();
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sweep_len("after_arst", N);
        for (int i = 0; i < N; i++) do_lookup("sweep_all", i, 1'b0, 1'b0);

        // Flush: train index 3 strong, queue updates, flush with competing requests.
        do_update(3, 1'b1);
        do_update(3, 1'b1);
        cycle();
        do_lookup("pre_flush", 3, 1'b1, 1'b1);
        do_update(3, 1'b0);
        do_update(3, 1'b0);
        flush        = 1'b1;
        lookup_valid = 1'b1;
        lookup_index = IB'(3);
        update_valid = 1'b1;
        update_index = IB'(3);
        update_taken = 1'b0;
        cycle();
        flush        = 1'b0;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        chk("flush_pred_valid",   pred_valid,   1'b0);
        chk("flush_update_ready", update_ready, 1'b1);
        chk("flush_busy",         busy,         1'b1);
        sweep_len("after_flush", N);
        do_lookup("post_flush", 3, 1'b0, 1'b0);

        // Randomized traffic on a narrow index range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            flush        = ($urandom_range(0, 99) == 0);
            lookup_valid = $urandom_range(0, 1);
            lookup_index = IB'($urandom_range(0, 7));
            update_valid = $urandom_range(0, 1);
            update_index = IB'($urandom_range(0, 7));
            update_taken = $urandom_range(0, 1);
            cycle();
        end
        flush        = 1'b0;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
